proj_gfm_collector: RTL and testbench

PROJ_GFM_COLLECTOR -- requirements
Module: proj_gfm_collector

---
 rtl/proj_pkg.sv | 19 +
 rtl/proj_window_fifo.sv | 61 ++++++
 rtl/proj_gfm_collector.sv | 129 ++++++++++++
 tb/tb_proj_gfm_collector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared constants and FSM state encoding for the GFM window collector.
package proj_pkg;

  localparam int unsigned FM_EXTENDER_FRAG_LEN_BITS     = 12;
  localparam int unsigned EXTENDER_OUT_PART_LEN         = 3;
  localparam int unsigned EXTENDER_PARTS_COUNT          =
      FM_EXTENDER_FRAG_LEN_BITS / EXTENDER_OUT_PART_LEN;
  localparam int unsigned EXTENDER_OUT_PART_LEN_ONE_HOT = 1 << EXTENDER_OUT_PART_LEN;
  localparam int unsigned SORTER_EXTENDER_INDICES_COUNT = 2;
  localparam int unsigned SIGNED_INDICE_LEN             = 8;
  localparam int unsigned EXTENDER_WINDOW_LEN           =
      EXTENDER_PARTS_COUNT * EXTENDER_OUT_PART_LEN_ONE_HOT;

  typedef logic [0:0] collector_state_t;

  localparam collector_state_t StIdle    = 1'b0;
  localparam collector_state_t StCollect = 1'b1;

endpackage

// File: rtl/proj_window_fifo.sv
// Power-of-two synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module proj_window_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/proj_gfm_collector.sv
// Assembles per-cycle one-hot parts into indexed windows and buffers them for a consumer.
module proj_gfm_collector
  import proj_pkg::*;
#(
  parameter int unsigned PARTS_COUNT       = proj_pkg::EXTENDER_PARTS_COUNT,
  parameter int unsigned PART_OH_LEN       = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT,
  parameter int unsigned INDICES_COUNT     = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int unsigned SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
  parameter int unsigned FIFO_DEPTH        = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_start,
  input  logic [SIGNED_INDICE_LEN-1:0]       in_index,
  input  logic [PART_OH_LEN-1:0]             in_gfm,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PARTS_COUNT*PART_OH_LEN-1:0] out_window,
  output logic [SIGNED_INDICE_LEN-1:0]       out_win_index,
  output logic                               out_last,
  output logic                               out_overflow
);

  localparam int unsigned WinW    = PARTS_COUNT * PART_OH_LEN;
  localparam int unsigned PartW   = (PARTS_COUNT > 1) ? $clog2(PARTS_COUNT) : 1;
  localparam int unsigned WinCntW = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
  localparam int unsigned EntryW  = 1 + SIGNED_INDICE_LEN + WinW;

  collector_state_t             state_q, state_d;
  logic [PartW-1:0]             part_q, part_d;
  logic [WinCntW-1:0]           win_q, win_d;
  logic [WinW-1:0]              acc_q, acc_d, acc_upd;
  logic [SIGNED_INDICE_LEN-1:0] idx_q, idx_d, idx_upd;
  logic                         ovf_q, ovf_d;

  logic              collecting, last_part, last_win, complete;
  logic              fifo_full, pop;
  logic [EntryW-1:0] push_data, head_data;

  assign collecting = (state_q == StCollect);
  assign last_part  = (part_q == PartW'(PARTS_COUNT - 1));
  assign last_win   = (win_q == WinCntW'(INDICES_COUNT - 1));
  assign complete   = collecting && last_part;
  assign pop        = out_valid && out_ready;

  // The completing part is merged combinationally so the window is pushed on its own edge.
  always_comb begin
    acc_upd = acc_q;
    for (int unsigned p = 0; p < PARTS_COUNT; p++) begin
      if (part_q == PartW'(p)) begin
        acc_upd[p*PART_OH_LEN +: PART_OH_LEN] = in_gfm;
      end
    end
    idx_upd   = (part_q == '0) ? in_index : idx_q;
    push_data = {last_win, idx_upd, acc_upd};
  end

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    win_d   = win_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    if (collecting) begin
      acc_d = acc_upd;
      idx_d = idx_upd;
      if (last_part) begin
        part_d = '0;
        if (last_win) begin
          win_d   = '0;
          state_d = StIdle;
        end else begin
          win_d = win_q + WinCntW'(1);
        end
      end else begin
        part_d = part_q + PartW'(1);
      end
    end

    // A restart wins over the window bookkeeping but never over the push of a completed window.
    if (in_start) begin
      state_d = StCollect;
      part_d  = '0;
      win_d   = '0;
    end

    if (complete && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      part_q  <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  proj_window_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (complete),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .data_o  (head_data)
  );

  assign {out_last, out_win_index, out_window} = head_data;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_proj_gfm_collector.sv
// Randomised and directed scoreboard bench for proj_gfm_collector.
module tb_proj_gfm_collector;

  localparam int P  = 4;
  localparam int L  = 8;
  localparam int I  = 2;
  localparam int D  = 2;
  localparam int IW = 8;
  localparam int WW = P * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_start;
  logic [IW-1:0] in_index;
  logic [L-1:0]  in_gfm;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
  logic [IW-1:0] out_win_index;
  logic          out_last;
  logic          out_overflow;

  always #5 clk = ~clk;

  proj_gfm_collector #(
    .PARTS_COUNT       (P),
    .PART_OH_LEN       (L),
    .INDICES_COUNT     (I),
    .SIGNED_INDICE_LEN (IW),
    .FIFO_DEPTH        (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_start      (in_start),
    .in_index      (in_index),
    .in_gfm        (in_gfm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_window    (out_window),
    .out_win_index (out_win_index),
    .out_last      (out_last),
    .out_overflow  (out_overflow)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic [IW-1:0] idx;
    logic          last;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: a batch is P*I parts; a window is every P consecutive parts.
  bit            m_active;
  int            m_k;
  logic [IW-1:0] m_idx;
  logic [WW-1:0] m_win;
  bit            exp_ovf, drop_pending, pushed_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] rand_oh();
    logic [L-1:0] v;
    v = L'(1) << $urandom_range(0, L - 1);
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_active     = 0;
    m_k          = 0;
    exp_ovf      = 0;
    drop_pending = 0;
    pushed_now   = 0;
  endtask

  task automatic step(input bit start, input logic [L-1:0] gfm, input logic [IW-1:0] idx,
                      input bit rdy);
    int p;
    entry_t e;
    @(negedge clk);
    #1;
    exp_ovf      = exp_ovf | drop_pending;
    drop_pending = 0;
    pushed_now   = 0;
    in_start  = start;
    in_gfm    = gfm;
    in_index  = idx;
    out_ready = rdy;
    if (m_active) begin
      p = m_k % P;
      if (p == 0) begin
        m_idx = idx;
        m_win = '0;
      end
      m_win = m_win | (WW'(gfm) << (L * p));
      if (p == P - 1) begin
        e.win  = m_win;
        e.idx  = m_idx;
        e.last = ((m_k / P) == I - 1);
        // Full and no pop this edge: the window is lost.
        if (exp_q.size() == D && !rdy) begin
          drop_pending = 1;
        end else begin
          exp_q.push_back(e);
          pushed_now = 1;
        end
      end
      m_k++;
      if (m_k == P * I) m_active = 0;
    end
    if (start) begin
      m_active = 1;
      m_k      = 0;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rand_oh(), IW'($urandom), rdy);
  endtask

  task automatic parts(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rand_oh(), IW'($urandom), rdy);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_overflow"}, 64'(out_overflow), 64'd0);
    check({tag, "_window"}, 64'(out_window), 64'd0);
    check({tag, "_index"}, 64'(out_win_index), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n    = 1'b0;
    in_start = 1'b0;
    model_clear();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: runs after the driver each cycle, sees the values the next edge will use.
  initial begin
    entry_t e;
    bit exp_valid;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        exp_valid = (exp_q.size() - int'(pushed_now)) > 0;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("out_overflow", 64'(out_overflow), 64'(exp_ovf));
        if (out_valid && out_ready && exp_valid) begin
          e = exp_q.pop_front();
          check("out_window", 64'(out_window), 64'(e.win));
          check("out_win_index", 64'(out_win_index), 64'(e.idx));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_start  = 1'b0;
    in_gfm    = '0;
    in_index  = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("init");
    rst_n = 1'b1;

    // Basic batch with fixed parts and signed indices.
    idle(2, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h01, 8'hFD, 1'b1);
    step(1'b0, 8'h02, 8'hFD, 1'b1);
    step(1'b0, 8'h04, 8'hFD, 1'b1);
    step(1'b0, 8'h08, 8'hFD, 1'b1);
    step(1'b0, 8'h10, 8'h05, 1'b1);
    step(1'b0, 8'h20, 8'h05, 1'b1);
    step(1'b0, 8'h40, 8'h05, 1'b1);
    step(1'b0, 8'h80, 8'h05, 1'b1);
    idle(3, 1'b1);

    // Full buffer, then pop and push on the same completion edge.
    step(1'b1, rand_oh(), 8'h00, 1'b0);
    parts(8, 1'b0);
    step(1'b1, rand_oh(), 8'h00, 1'b0);
    parts(3, 1'b0);
    parts(5, 1'b1);
    idle(4, 1'b1);

    // Restart on part 2 of window 0, also restart on a completion cycle.
    step(1'b1, rand_oh(), 8'h00, 1'b1);
    parts(2, 1'b1);
    step(1'b1, rand_oh(), IW'($urandom), 1'b1);
    parts(7, 1'b1);
    step(1'b1, rand_oh(), IW'($urandom), 1'b1);
    parts(8, 1'b1);
    idle(3, 1'b1);

    // Reset mid-window with one entry buffered.
    step(1'b1, rand_oh(), 8'h00, 1'b0);
    parts(6, 1'b0);
    do_reset();
    idle(6, 1'b1);

    // Backpressure across two batches: second batch is dropped.
    step(1'b1, rand_oh(), 8'h00, 1'b0);
    parts(8, 1'b0);
    step(1'b1, rand_oh(), 8'h00, 1'b0);
    parts(8, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      bit st;
      st = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      step(st, rand_oh(), IW'($urandom), $urandom_range(0, 9) < 7);
    end

    idle(10, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
